scan_chain_driver: RTL and testbench
====================================

SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

Interface
REQ-001 Parameter NUM_DESIGNS, default 5: number of scanchain slots in the chain; chain length L = 8*NUM_DESIGNS bits.
REQ-002 Parameter CLK_DIV, default 2: scan clock half-period in clk cycles, legal range 1..255.
REQ-003 Port clk  input  1  system clock; all logic is clocked on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle request for one chain transaction; sampled only in IDLE.
REQ-006 Port active_select  input  9  target slot index d; sampled on accepted start.
REQ-007 Port inputs  input  8  data for the target slot's module inputs; sampled on accepted start.
REQ-008 Port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 Port done  output  1  one-cycle pulse on transaction completion.
REQ-010 Port err  output  1  high in the done cycle when d >= NUM_DESIGNS.
REQ-011 Port outputs  output  8  captured module outputs of slot d; held until the next done.
REQ-012 Port scan_clk_out  output  1  chain shift clock toward the first scanchain.
REQ-013 Port scan_data_out  output  1  serial data toward the first scanchain.
REQ-014 Port scan_select  output  1  1 = chain flops capture module outputs on the scan clock edge.
REQ-015 Port scan_latch_en  output  1  transfers chain contents to the module input latches.
REQ-016 Port scan_data_in  input  1  serial return from the last scanchain.

Function
REQ-017 States IDLE -> CAPTURE -> SHIFT -> LATCH -> DONE -> IDLE; start in any non-IDLE state is ignored.
REQ-018 Accepted start with d >= NUM_DESIGNS goes IDLE -> DONE directly: no scan activity, err=1, outputs unchanged.
REQ-019 Scan clock pulse: scan_clk_out low for CLK_DIV cycles, then high for CLK_DIV cycles; all scan signals change only while scan_clk_out is low.
REQ-020 CAPTURE: scan_select=1 for exactly one scan clock pulse, then 0 before SHIFT begins.
REQ-021 SHIFT: exactly L scan clock pulses with shift index k = 0..L-1, driven by an internal counter of width clog2(L+1).
REQ-022 Chain position p = 8*slot + bit, with p=0 nearest this block; bit driven at index k lands at position L-1-k.
REQ-023 scan_data_out at index k = inputs[i] when k = L-1-8d-i for i in 0..7; otherwise 0.
REQ-024 scan_data_in is sampled on the last clk cycle before each rising scan_clk_out; the sample at k = L-1-8d-i is stored as outputs[i].
REQ-025 LATCH: scan_clk_out=0; scan_latch_en=1 for exactly 2 clk cycles; then 1 clk of settle with all scan outputs 0.
REQ-026 DONE: lasts one cycle; outputs are updated atomically in this cycle; done=1, busy=0 on the following IDLE.
REQ-027 Transaction latency = 1 + 2*CLK_DIV*(L+1) + 3 clk cycles from accepted start to done.

Reset
REQ-028 With reset low at a clk edge: state=IDLE; busy, done, err, scan_clk_out, scan_data_out, scan_select and scan_latch_en = 0; outputs = 8'h00; counters = 0.
REQ-029 Reset mid-transaction aborts immediately with no further scan clock edge or latch pulse; start is ignored while reset is low.

Structure
REQ-030 A shared package holds the state enum and the default values of NUM_DESIGNS and CLK_DIV.
REQ-031 One sub-module, scan_clk_gen, holds the CLK_DIV divider; it produces pulse phases and a sample strobe, enabled only in CAPTURE and SHIFT.

Verification
REQ-032 NUM_DESIGNS=5, CLK_DIV=2, behavioural 40-bit chain model; start, d=3, inputs=8'hA5 -> model slot 3 latches 8'hA5, all other slots 0, done at cycle 1+4*41+3=168.
REQ-033 Slot 0 outputs preloaded 8'h3C; start, d=0 -> outputs=8'h3C, err=0.
REQ-034 Start with d=5 -> done one cycle later, err=1, no scan_clk_out edge, outputs unchanged.
REQ-035 Reset driven low at SHIFT index 17 -> all scan outputs 0 next cycle and state IDLE; no latch pulse; a new transaction then completes correctly.
REQ-036 start held high continuously -> back-to-back transactions; none overlap; scan_latch_en high exactly 2 cycles per transaction.
REQ-037 CLK_DIV=1, d=4, inputs=8'hFF -> scan_clk_out toggles every cycle, 41 pulses, slot 4 receives 8'hFF.

Source files
------------

// File: rtl/scan_chain_driver_pkg.sv
// Shared types and default sizing for the scan chain driver.
package scan_chain_driver_pkg;

    localparam int DEF_NUM_DESIGNS = 5;
    localparam int DEF_CLK_DIV     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/scan_chain_driver_if.sv
// Host-side request/response bundle of the scan chain driver.
interface scan_chain_driver_if;

    logic       start;
    logic [8:0] active_select;
    logic [7:0] inputs;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] outputs;

    modport master (
        output start, active_select, inputs,
        input  busy, done, err, outputs
    );

    modport slave (
        input  start, active_select, inputs,
        output busy, done, err, outputs
    );

endinterface

// File: rtl/scan_clk_gen.sv
// Scan clock divider: low CLK_DIV cycles, high CLK_DIV cycles, with strobes
// for the last low cycle (sample) and the last high cycle (pulse end).
module scan_clk_gen
    import scan_chain_driver_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic scan_clk_o,
    output logic sample_o,
    output logic pulse_end_o
);

    localparam int CW = 9;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          scan_clk_q;

    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != CW'(2*CLK_DIV-1))) cnt_d = cnt_q + 1'b1;
    end

    // Registered so the chain clock is glitch-free; it follows the next count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q      <= '0;
            scan_clk_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            scan_clk_q <= (cnt_d >= CW'(CLK_DIV));
        end
    end

    assign scan_clk_o  = scan_clk_q;
    assign sample_o    = en_i && (cnt_q == CW'(CLK_DIV-1));
    assign pulse_end_o = en_i && (cnt_q == CW'(2*CLK_DIV-1));

endmodule

// File: rtl/scan_chain_driver.sv
// Drives one capture/shift/latch transaction over a chain of 8-bit scan slots,
// writing the target slot's inputs and returning its captured outputs.
module scan_chain_driver
    import scan_chain_driver_pkg::*;
#(
    parameter int NUM_DESIGNS = DEF_NUM_DESIGNS,
    parameter int CLK_DIV     = DEF_CLK_DIV
) (
    input  logic                clk,
    input  logic                reset,
    scan_chain_driver_if.slave  host,
    output logic                scan_clk_out,
    output logic                scan_data_out,
    output logic                scan_select,
    output logic                scan_latch_en,
    input  logic                scan_data_in
);

    localparam int L  = 8*NUM_DESIGNS;
    localparam int KW = $clog2(L+1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [8:0]    sel_q, sel_d;
    logic [7:0]    in_q, in_d;
    logic [7:0]    cap_q, cap_d;
    logic [7:0]    out_q, out_d;
    logic          bad_q, bad_d;

    logic          clk_en, sample, pulse_end;
    logic [KW-1:0] pos;
    logic          hit;

    assign clk_en = (state_q == ST_CAPTURE) || (state_q == ST_SHIFT);

    scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk         (clk),
        .reset       (reset),
        .en_i        (clk_en),
        .scan_clk_o  (scan_clk_out),
        .sample_o    (sample),
        .pulse_end_o (pulse_end)
    );

    // Shift index k reaches chain position L-1-k; hit marks the target slot.
    assign pos = KW'(L-1) - k_q;
    assign hit = (32'(pos >> 3) == 32'(sel_q));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sel_d   = sel_q;
        in_d    = in_q;
        cap_d   = cap_q;
        out_d   = out_q;
        bad_d   = bad_q;
        unique case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    sel_d   = host.active_select;
                    in_d    = host.inputs;
                    k_d     = '0;
                    bad_d   = 32'(host.active_select) >= NUM_DESIGNS;
                    state_d = bad_d ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (pulse_end) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sample && hit) cap_d[pos[2:0]] = scan_data_in;
                if (pulse_end) begin
                    if (k_q == KW'(L-1)) begin
                        k_d     = '0;
                        state_d = ST_LATCH;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                // Two latch-enable cycles, then one settle cycle.
                k_d = k_q + 1'b1;
                if (k_q == KW'(2)) begin
                    k_d     = '0;
                    out_d   = cap_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            sel_q   <= '0;
            in_q    <= '0;
            cap_q   <= '0;
            out_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sel_q   <= sel_d;
            in_q    <= in_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
            bad_q   <= bad_d;
        end
    end

    assign scan_select   = (state_q == ST_CAPTURE);
    assign scan_latch_en = (state_q == ST_LATCH) && (k_q != KW'(2));
    assign scan_data_out = (state_q == ST_SHIFT) && hit && in_q[pos[2:0]];

    assign host.busy    = (state_q == ST_CAPTURE) || (state_q == ST_SHIFT) ||
                          (state_q == ST_LATCH);
    assign host.done    = (state_q == ST_DONE);
    assign host.err     = (state_q == ST_DONE) && bad_q;
    assign host.outputs = out_q;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Scoreboard bench: two drivers (CLK_DIV=2 and CLK_DIV=1) each on a 40-bit chain model.
module tb_scan_chain_driver;

    localparam int ND = 5;
    localparam int L  = 8*ND;

    typedef struct {
        int           u;
        int           exp_cyc;
        logic         err;
        logic [7:0]   outs;
        int           pulses;
        int           lats;
        logic         slot_chk;
        logic [L-1:0] mchain;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    logic         start_r   [2];
    logic [8:0]   sel_r     [2];
    logic [7:0]   in_r      [2];
    logic [L-1:0] mod_out_r [2];
    logic [7:0]   last_outs [2];

    logic         done_w [2];
    logic         busy_w [2];
    logic         err_w  [2];
    logic         sclk_w [2];
    logic         sdo_w  [2];
    logic         ssel_w [2];
    logic         slat_w [2];
    logic [7:0]   outs_w [2];
    logic [L-1:0] min_w  [2];

    int   pulses    [2] = '{0, 0};
    int   lats      [2] = '{0, 0};
    int   lat_total [2] = '{0, 0};
    logic sclk_prev [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar u = 0; u < 2; u++) begin : g_u
        localparam int CD = (u == 0) ? 2 : 1;
        scan_chain_driver_if hif ();
        logic         sclk, sdo, ssel, slat;
        logic [L-1:0] chain  = '0;
        logic [L-1:0] mod_in = '0;

        assign hif.start         = start_r[u];
        assign hif.active_select = sel_r[u];
        assign hif.inputs        = in_r[u];

        scan_chain_driver #(.NUM_DESIGNS(ND), .CLK_DIV(CD)) dut (
            .clk           (clk),
            .reset         (rst_n),
            .host          (hif),
            .scan_clk_out  (sclk),
            .scan_data_out (sdo),
            .scan_select   (ssel),
            .scan_latch_en (slat),
            .scan_data_in  (chain[L-1])
        );

        // Position 0 is nearest the driver; data enters there and moves up.
        always @(posedge sclk) chain <= ssel ? mod_out_r[u] : {chain[L-2:0], sdo};
        always @(posedge clk) if (slat) mod_in <= chain;

        assign done_w[u] = hif.done;
        assign busy_w[u] = hif.busy;
        assign err_w[u]  = hif.err;
        assign outs_w[u] = hif.outputs;
        assign sclk_w[u] = sclk;
        assign sdo_w[u]  = sdo;
        assign ssel_w[u] = ssel;
        assign slat_w[u] = slat;
        assign min_w[u]  = mod_in;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int cdv(int u);
        return (u == 0) ? 2 : 1;
    endfunction

    task automatic wait_sb();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    task automatic txn(int u, int d, logic [7:0] ins, logic [7:0] mo, bit wait_done);
        exp_t e;
        bit   ok = (d < ND);
        @(negedge clk);
        if (ok) mod_out_r[u][8*d +: 8] = mo;
        e.u        = u;
        e.err      = !ok;
        e.exp_cyc  = cyc + (ok ? 1 + 2*cdv(u)*(L+1) + 3 : 1);
        e.outs     = ok ? mo : last_outs[u];
        e.pulses   = ok ? L+1 : 0;
        e.lats     = ok ? 2 : 0;
        e.slot_chk = ok;
        e.mchain   = '0;
        if (ok) begin
            e.mchain[8*d +: 8] = ins;
            last_outs[u] = mo;
        end
        sb.push_back(e);
        start_r[u] = 1'b1;
        sel_r[u]   = 9'(d);
        in_r[u]    = ins;
        @(negedge clk);
        start_r[u] = 1'b0;
        if (wait_done) wait_sb();
    endtask

    // Monitor: counts scan pulses / latch cycles per transaction, checks on done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (slat_w[u]) lat_total[u]++;
                if (!rst_n) begin
                    pulses[u] = 0;
                    lats[u]   = 0;
                end else begin
                    if (sclk_w[u] && !sclk_prev[u]) pulses[u]++;
                    if (slat_w[u]) lats[u]++;
                    if (done_w[u]) begin
                        chk("expected_done_pending", 64'(sb.size() != 0), 64'(1));
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            chk("done_unit", 64'(u), 64'(e.u));
                            chk("done_cycle", 64'(cyc), 64'(e.exp_cyc));
                            chk("err", 64'(err_w[u]), 64'(e.err));
                            chk("outputs", 64'(outs_w[u]), 64'(e.outs));
                            chk("busy_at_done", 64'(busy_w[u]), 64'(0));
                            chk("scan_pulses", 64'(pulses[u]), 64'(e.pulses));
                            chk("latch_cycles", 64'(lats[u]), 64'(e.lats));
                            if (e.slot_chk) chk("model_latched", 64'(min_w[u]), 64'(e.mchain));
                        end
                        pulses[u] = 0;
                        lats[u]   = 0;
                    end
                end
                sclk_prev[u] = sclk_w[u];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t h;
        int   lt0;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_r[u]   = 1'b0;
            sel_r[u]     = '0;
            in_r[u]      = '0;
            mod_out_r[u] = '0;
            last_outs[u] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_outputs", 64'(outs_w[0]), 64'(0));
        chk("rst_busy", 64'(busy_w[0]), 64'(0));
        chk("rst_done", 64'(done_w[0]), 64'(0));
        chk("rst_err", 64'(err_w[0]), 64'(0));
        chk("rst_scan_clk", 64'(sclk_w[0]), 64'(0));
        chk("rst_scan_data", 64'(sdo_w[0]), 64'(0));
        chk("rst_scan_select", 64'(ssel_w[0]), 64'(0));
        chk("rst_latch_en", 64'(slat_w[0]), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        txn(0, 3, 8'hA5, 8'h96, 1'b1);
        txn(0, 0, 8'h81, 8'h3C, 1'b1);
        txn(0, 5, 8'hFF, 8'h00, 1'b1);
        txn(0, 4, 8'h7E, 8'hC3, 1'b1);

        // Abort during shift index 17 (cycles 73..76 after the start cycle).
        lt0 = lat_total[0];
        txn(0, 1, 8'h12, 8'hE1, 1'b0);
        last_outs[0] = 8'hC3;
        repeat (73) @(negedge clk);
        rst_n      = 1'b0;
        start_r[0] = 1'b1;
        sel_r[0]   = 9'd1;
        @(negedge clk);
        chk("abort_scan_clk", 64'(sclk_w[0]), 64'(0));
        chk("abort_scan_data", 64'(sdo_w[0]), 64'(0));
        chk("abort_scan_select", 64'(ssel_w[0]), 64'(0));
        chk("abort_latch_en", 64'(slat_w[0]), 64'(0));
        chk("abort_busy", 64'(busy_w[0]), 64'(0));
        repeat (2) @(negedge clk);
        chk("abort_start_ignored", 64'(busy_w[0]), 64'(0));
        start_r[0] = 1'b0;
        rst_n      = 1'b1;
        sb.delete();
        repeat (20) @(negedge clk);
        chk("abort_idle", 64'(busy_w[0]), 64'(0));
        chk("abort_no_latch", 64'(lat_total[0]), 64'(lt0));
        chk("abort_outputs", 64'(outs_w[0]), 64'(8'h00));
        last_outs[0] = 8'h00;

        txn(0, 1, 8'h12, 8'hE1, 1'b1);

        // start held high: two back-to-back transactions, one IDLE cycle apart.
        @(negedge clk);
        mod_out_r[0][23:16] = 8'h0F;
        for (int j = 0; j < 2; j++) begin
            h.u        = 0;
            h.err      = 1'b0;
            h.exp_cyc  = cyc + (1 + 4*(L+1) + 3) + j*(1 + 4*(L+1) + 4);
            h.outs     = 8'h0F;
            h.pulses   = L+1;
            h.lats     = 2;
            h.slot_chk = 1'b1;
            h.mchain   = '0;
            h.mchain[23:16] = 8'h4D;
            sb.push_back(h);
        end
        start_r[0] = 1'b1;
        sel_r[0]   = 9'd2;
        in_r[0]    = 8'h4D;
        repeat (200) @(negedge clk);
        start_r[0]   = 1'b0;
        last_outs[0] = 8'h0F;
        wait_sb();

        txn(1, 4, 8'hFF, 8'hA0, 1'b1);
        txn(1, 2, 8'h5A, 8'h33, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
